// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage.
package wb_pkg;

  // Widest datapath the stage supports. Entries are stored at this width
  // and the top trims to its XLEN.
  localparam int XLEN_MAX = 64;
  localparam int OFF_MAX  = 3;

  typedef enum logic [3:0] {
    OP_MATH = 4'd0,
    OP_LDST = 4'd1,
    OP_BR   = 4'd2,
    OP_JMP  = 4'd3,
    OP_UIMM = 4'd4
  } op_type_e;

  localparam logic [4:0] SPEC_LB  = 5'd0;
  localparam logic [4:0] SPEC_LH  = 5'd1;
  localparam logic [4:0] SPEC_LW  = 5'd2;
  localparam logic [4:0] SPEC_LBU = 5'd3;
  localparam logic [4:0] SPEC_LHU = 5'd4;
  localparam logic [4:0] SPEC_SB  = 5'd5;
  localparam logic [4:0] SPEC_SH  = 5'd6;
  localparam logic [4:0] SPEC_SW  = 5'd7;
  localparam logic [4:0] SPEC_LD  = 5'd8;
  localparam logic [4:0] SPEC_LWU = 5'd9;

  // op_type is kept as raw bits: unknown encodings must survive the buffer.
  typedef struct packed {
    logic [3:0]          op_type;
    logic [4:0]          op_spec;
    logic [4:0]          rd_ind;
    logic [XLEN_MAX-1:0] rd_dat;
    logic [XLEN_MAX-1:0] mem_dat;
    logic [OFF_MAX-1:0]  mem_off;
    logic [XLEN_MAX-1:0] jmp_addr;
    logic                jmp_take;
  } wb_entry_t;

  function automatic logic is_load(logic [4:0] spec);
    logic r;
    case (spec)
      SPEC_LB, SPEC_LH, SPEC_LW, SPEC_LBU, SPEC_LHU, SPEC_LD, SPEC_LWU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // True when the entry needs the register-file write port (x0 never does).
  function automatic logic writes_rd(wb_entry_t e);
    logic w;
    case (e.op_type)
      OP_MATH, OP_JMP, OP_UIMM: w = 1'b1;
      OP_LDST:                  w = is_load(e.op_spec);
      default:                  w = 1'b0;
    endcase
    return w && (e.rd_ind != 5'd0);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment and sign/zero extension (combinational).
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  mem_dat_i,
  input  logic [OFF_W-1:0] mem_off_i,
  input  logic [4:0]       op_spec_i,
  output logic [XLEN-1:0]  data_o
);

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] lw_s;

  // Shift the addressed byte to bit 0; overrun offsets zero-fill the top.
  always_comb begin
    sh     = mem_dat_i >> {mem_off_i, 3'b000};
    lw_s   = XLEN'($signed(sh[31:0]));
    data_o = '0;
    case (op_spec_i)
      SPEC_LB:  data_o = XLEN'($signed(sh[7:0]));
      SPEC_LH:  data_o = XLEN'($signed(sh[15:0]));
      SPEC_LW:  data_o = lw_s;
      SPEC_LBU: data_o = XLEN'(sh[7:0]);
      SPEC_LHU: data_o = XLEN'(sh[15:0]);
      // On a 32-bit datapath ld and lwu collapse to lw.
      SPEC_LD:  data_o = (XLEN == 64) ? sh : lw_s;
      SPEC_LWU: data_o = (XLEN == 64) ? XLEN'(sh[31:0]) : lw_s;
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage_skid.sv
// Writeback stage: 2-entry skid buffer, load align, redirect, retire count.
module wb_stage_skid
  import wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int CNT_W = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op_type,
  input  logic [4:0]       in_op_spec,
  input  logic [4:0]       in_rd_ind,
  input  logic [XLEN-1:0]  in_rd_dat,
  input  logic [XLEN-1:0]  in_mem_dat,
  input  logic [OFF_W-1:0] in_mem_off,
  input  logic [XLEN-1:0]  in_jmp_addr,
  input  logic             in_jmp_take,
  input  logic             rf_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             jmp_take_out,
  output logic [XLEN-1:0]  jmp_addr_out,
  output logic [CNT_W-1:0] retire_cnt
);

  wb_entry_t [1:0] buf_q, buf_d;
  logic [1:0]      cnt_q, cnt_d;
  wb_entry_t       in_e, head;
  logic            accept, head_vld, head_wr, retire, redirect;
  logic [XLEN-1:0] ld_data, wdata;

  logic             rf_we_q, jmp_take_q;
  logic [4:0]       rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q, jmp_addr_q;
  logic [CNT_W-1:0] retire_cnt_q;

  // Pack the incoming fields into a full-width entry.
  always_comb begin
    in_e          = '0;
    in_e.op_type  = in_op_type;
    in_e.op_spec  = in_op_spec;
    in_e.rd_ind   = in_rd_ind;
    in_e.rd_dat   = XLEN_MAX'(in_rd_dat);
    in_e.mem_dat  = XLEN_MAX'(in_mem_dat);
    in_e.mem_off  = OFF_MAX'(in_mem_off);
    in_e.jmp_addr = XLEN_MAX'(in_jmp_addr);
    in_e.jmp_take = in_jmp_take;
  end

  // Ready is a function of stored occupancy only, so it never combinationally
  // depends on rf_ready.
  assign in_ready = !rst && (cnt_q < 2'd2);
  assign accept   = in_valid && in_ready;

  assign head     = (cnt_q != 2'd0) ? buf_q[0] : in_e;
  assign head_vld = (cnt_q != 2'd0) || accept;
  assign head_wr  = writes_rd(head);
  assign retire   = head_vld && (!head_wr || rf_ready);
  assign redirect = retire && ((head.op_type == OP_JMP) ||
                               ((head.op_type == OP_BR) && head.jmp_take));

  // Upper halves of the wide entry are dead when XLEN is 32.
  logic unused_head;
  assign unused_head = ^head;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .mem_dat_i (head.mem_dat[XLEN-1:0]),
    .mem_off_i (head.mem_off[OFF_W-1:0]),
    .op_spec_i (head.op_spec),
    .data_o    (ld_data)
  );

  assign wdata = (head.op_type == OP_LDST) ? ld_data : head.rd_dat[XLEN-1:0];

  // FIFO next state; a redirect flushes everything younger, including
  // an entry accepted in the same cycle.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (redirect) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: if (accept && !retire) begin
          buf_d[0] = in_e;
          cnt_d    = 2'd1;
        end
        2'd1: begin
          if (retire && accept) begin
            buf_d[0] = in_e;
          end else if (retire) begin
            cnt_d = 2'd0;
          end else if (accept) begin
            buf_d[1] = in_e;
            cnt_d    = 2'd2;
          end
        end
        default: if (retire) begin
          buf_d[0] = buf_q[1];
          cnt_d    = 2'd1;
        end
      endcase
    end
  end

  // Buffer state and registered retirement outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 2'd0;
      buf_q        <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      jmp_take_q   <= 1'b0;
      jmp_addr_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      rf_we_q    <= retire && head_wr;
      jmp_take_q <= redirect;
      if (retire && head_wr) begin
        rf_waddr_q <= head.rd_ind;
        rf_wdata_q <= wdata;
      end
      if (redirect) jmp_addr_q <= head.jmp_addr[XLEN-1:0];
      if (retire)   retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign jmp_take_out = jmp_take_q;
  assign jmp_addr_out = jmp_addr_q;
  assign retire_cnt   = retire_cnt_q;

endmodule
